// File: rtl/handshake_rr_arbiter.sv
// -----------------------------------------------------------------------------
// handshake_rr_arbiter
//   Packet-aware round-robin arbiter that merges N valid/ready source channels
//   onto one valid/ready destination through a single registered output stage
//   (1-cycle latency, one beat per cycle when the destination is ready).
//   A source that wins keeps the destination until it sends its last beat.
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   valid_s  per-source valid (bit i = source i)
//   data_s   per-source data, source i at [i*W +: W]
//   last_s   per-source end-of-packet flag, qualified by valid_s
//   ready_s  per-source ready (combinational, at most one bit high)
//   valid_d  destination valid (registered)
//   data_d   destination data (registered)
//   last_d   destination end-of-packet (registered)
//   src_d    index of the source that produced data_d (registered)
//   ready_d  destination ready
// -----------------------------------------------------------------------------
module handshake_rr_arbiter #(
    parameter int N   = 4,
    parameter int W   = 8,
    parameter int IDW = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     valid_s,
    input  logic [N*W-1:0]   data_s,
    input  logic [N-1:0]     last_s,
    output logic [N-1:0]     ready_s,
    output logic             valid_d,
    output logic [W-1:0]     data_d,
    output logic             last_d,
    output logic [IDW-1:0]   src_d,
    input  logic             ready_d
);

    localparam int NS = 2 ** IDW;

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [IDW-1:0] r_ptr;
    logic [IDW-1:0] w_ptr_nxt;
    logic [IDW-1:0] r_owner;
    logic [IDW-1:0] w_owner_nxt;

    logic           r_valid_d;
    logic [W-1:0]   r_data_d;
    logic           r_last_d;
    logic [IDW-1:0] r_src_d;

    logic [IDW-1:0] w_gnt;
    logic           w_gnt_vld;
    logic           w_load_en;
    logic           w_xfer;

    // Source vectors padded to 2**IDW entries so an IDW-bit grant index
    // selects exactly; padding entries are never valid.
    logic [NS-1:0]  w_valid_ext;
    logic [NS-1:0]  w_last_ext;
    logic [W-1:0]   w_data_arr [NS];

    for (genvar gi = 0; gi < NS; gi++) begin : g_ext
        if (gi < N) begin : g_src
            assign w_valid_ext[gi] = valid_s[gi];
            assign w_last_ext[gi]  = last_s[gi];
            assign w_data_arr[gi]  = data_s[gi*W +: W];
        end else begin : g_pad
            assign w_valid_ext[gi] = 1'b0;
            assign w_last_ext[gi]  = 1'b0;
            assign w_data_arr[gi]  = '0;
        end
    end

    assign w_load_en = ~r_valid_d | ready_d;
    assign w_xfer    = w_load_en & w_gnt_vld & w_valid_ext[w_gnt];

    function automatic logic [IDW-1:0] f_next_idx(input logic [IDW-1:0] idx);
        return (idx == IDW'(N - 1)) ? '0 : idx + 1'b1;
    endfunction

    // State register: FSM state, round-robin pointer and packet owner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_owner <= w_owner_nxt;
        end
    end

    // Next-state logic, including the grant selection.
    always_comb begin
        logic [IDW:0]   v_sum;
        logic [IDW-1:0] v_idx;
        w_gnt       = '0;
        w_gnt_vld   = 1'b0;
        v_sum       = '0;
        v_idx       = '0;
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;

        if (r_state == ST_LOCKED) begin
            w_gnt     = r_owner;
            w_gnt_vld = 1'b1;
        end else begin
            // Scan ptr, ptr+1, ... modulo N; the first valid source wins.
            for (int unsigned k = 0; k < N; k++) begin
                v_sum = {1'b0, r_ptr} + (IDW+1)'(k);
                if (v_sum >= (IDW+1)'(N)) begin
                    v_sum = v_sum - (IDW+1)'(N);
                end
                v_idx = v_sum[IDW-1:0];
                if (!w_gnt_vld && w_valid_ext[v_idx]) begin
                    w_gnt     = v_idx;
                    w_gnt_vld = 1'b1;
                end
            end
        end

        if (w_xfer) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_last_ext[w_gnt]) begin
                        w_ptr_nxt = f_next_idx(w_gnt);
                    end else begin
                        w_state_nxt = ST_LOCKED;
                        w_owner_nxt = w_gnt;
                    end
                end
                ST_LOCKED: begin
                    if (w_last_ext[w_gnt]) begin
                        w_state_nxt = ST_IDLE;
                        w_ptr_nxt   = f_next_idx(r_owner);
                    end
                end
                default: ;
            endcase
        end
    end

    // Output logic: per-source ready. In LOCKED the owner sees ready
    // whether or not it is currently valid.
    always_comb begin
        ready_s = '0;
        for (int unsigned i = 0; i < N; i++) begin
            ready_s[i] = w_load_en & w_gnt_vld & (w_gnt == IDW'(i)) &
                         ((r_state == ST_LOCKED) | valid_s[i]);
        end
    end

    // Registered output stage; payload holds when nothing new is loaded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid_d <= 1'b0;
            r_data_d  <= '0;
            r_last_d  <= 1'b0;
            r_src_d   <= '0;
        end else if (w_load_en) begin
            r_valid_d <= w_xfer;
            if (w_xfer) begin
                r_data_d <= w_data_arr[w_gnt];
                r_last_d <= w_last_ext[w_gnt];
                r_src_d  <= w_gnt;
            end
        end
    end

    assign valid_d = r_valid_d;
    assign data_d  = r_data_d;
    assign last_d  = r_last_d;
    assign src_d   = r_src_d;

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_handshake_rr_arbiter
//   Directed bench for handshake_rr_arbiter: a 4-source instance covers reset,
//   round robin, packet lock, bubbles, backpressure and async reset; a
//   3-source instance covers pointer wrap with a skipped source.
// -----------------------------------------------------------------------------
module tb_handshake_rr_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  valid_s;
    logic [31:0] data_s;
    logic [3:0]  last_s;
    logic [3:0]  ready_s;
    logic        valid_d;
    logic [7:0]  data_d;
    logic        last_d;
    logic [1:0]  src_d;
    logic        ready_d;

    logic [2:0]  v3;
    logic [23:0] d3;
    logic [2:0]  l3;
    logic [2:0]  r3;
    logic        vd3;
    logic [7:0]  dd3;
    logic        ld3;
    logic [1:0]  sd3;

    int n_checks = 0;
    int n_errors = 0;

    handshake_rr_arbiter #(.N(4), .W(8), .IDW(2)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .valid_s (valid_s),
        .data_s  (data_s),
        .last_s  (last_s),
        .ready_s (ready_s),
        .valid_d (valid_d),
        .data_d  (data_d),
        .last_d  (last_d),
        .src_d   (src_d),
        .ready_d (ready_d)
    );

    handshake_rr_arbiter #(.N(3), .W(8), .IDW(2)) u_dut3 (
        .clk     (clk),
        .rst     (rst),
        .valid_s (v3),
        .data_s  (d3),
        .last_s  (l3),
        .ready_s (r3),
        .valid_d (vd3),
        .data_d  (dd3),
        .last_d  (ld3),
        .src_d   (sd3),
        .ready_d (1'b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    // Source-side rule: a pending beat (valid & ~ready) must stay put.
    logic [3:0]  pend;
    logic [31:0] pdata;
    logic [3:0]  plast;
    always @(posedge clk) begin
        if (rst) begin
            pend <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (pend[i]) begin
                    assert (valid_s[i] && data_s[i*8 +: 8] == pdata[i*8 +: 8] &&
                            last_s[i] == plast[i])
                    else $error("source %0d changed a pending beat", i);
                end
            end
            pend  <= valid_s & ~ready_s;
            pdata <= data_s;
            plast <= last_s;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic [7:0] d, input logic l);
        data_s[i*8 +: 8] = d;
        last_s[i]        = l;
    endtask

    initial begin
        // ---------------- reset, then round robin of single beats ----------
        rst     = 1'b1;
        ready_d = 1'b1;
        valid_s = 4'b1111;
        last_s  = 4'b1111;
        for (int i = 0; i < 4; i++) data_s[i*8 +: 8] = 8'h10 + 8'(i);
        v3 = '0;
        l3 = 3'b111;
        d3 = {8'h22, 8'h21, 8'h20};
        step();
        step();
        check("rst_valid", valid_d, 0);
        check("rst_src",   src_d,   0);
        check("rst_data",  data_d,  0);
        check("rst_last",  last_d,  0);
        rst = 1'b0;
        #1;
        check("rr_rdy_first", ready_s, 4'b0001);
        for (int k = 0; k < 8; k++) begin
            step();
            check("rr_valid", valid_d, 1);
            check("rr_data",  data_d,  32'h10 + (k % 4));
            check("rr_src",   src_d,   k % 4);
            check("rr_rdy",   ready_s, 1 << ((k + 1) % 4));
        end

        // ---------------- packet lock: source 1 vs source 2 ----------------
        rst     = 1'b1;
        valid_s = 4'b0110;
        set_src(1, 8'hA1, 1'b0);
        set_src(2, 8'hB0, 1'b1);
        step();
        rst = 1'b0;
        #1;
        check("lk_rdy0", ready_s, 4'b0010);
        step();
        set_src(1, 8'hA2, 1'b0);
        #1;
        check("lk_a1",     data_d,  8'hA1);
        check("lk_a1_src", src_d,   1);
        check("lk_rdy1",   ready_s, 4'b0010);
        step();
        set_src(1, 8'hA3, 1'b1);
        #1;
        check("lk_a2",   data_d,  8'hA2);
        check("lk_rdy2", ready_s, 4'b0010);
        step();
        valid_s = 4'b0100;
        #1;
        check("lk_a3",      data_d,  8'hA3);
        check("lk_a3_last", last_d,  1);
        check("lk_rdy3",    ready_s, 4'b0100);
        step();
        valid_s = 4'b0000;
        #1;
        check("lk_b0",     data_d, 8'hB0);
        check("lk_b0_src", src_d,  2);
        step();
        check("lk_idle", valid_d, 0);

        // ---------------- packet lock with owner bubble --------------------
        rst     = 1'b1;
        valid_s = 4'b0110;
        set_src(1, 8'hA1, 1'b0);
        set_src(2, 8'hB0, 1'b1);
        step();
        rst = 1'b0;
        step();
        valid_s = 4'b0100;
        #1;
        check("bb_a1",   data_d,  8'hA1);
        check("bb_rdy0", ready_s, 4'b0010);
        step();
        check("bb_bub0",  valid_d, 0);
        check("bb_rdy1",  ready_s, 4'b0010);
        step();
        check("bb_bub1",  valid_d, 0);
        valid_s = 4'b0110;
        set_src(1, 8'hA2, 1'b1);
        #1;
        check("bb_rdy2", ready_s, 4'b0010);
        step();
        valid_s = 4'b0100;
        #1;
        check("bb_a2",     data_d,  8'hA2);
        check("bb_a2_src", src_d,   1);
        check("bb_rdy3",   ready_s, 4'b0100);
        step();
        valid_s = 4'b0000;
        #1;
        check("bb_b0",     data_d, 8'hB0);
        check("bb_b0_src", src_d,  2);

        // ---------------- backpressure on source 0 -------------------------
        rst     = 1'b1;
        valid_s = 4'b0001;
        set_src(0, 8'h35, 1'b0);
        step();
        rst = 1'b0;
        step();
        set_src(0, 8'hAC, 1'b0);
        ready_d = 1'b0;
        #1;
        check("bp_35",      data_d,  8'h35);
        check("bp_rdy_lo0", ready_s, 4'b0000);
        step();
        check("bp_hold0",   data_d,  8'h35);
        check("bp_vhold0",  valid_d, 1);
        check("bp_rdy_lo1", ready_s, 4'b0000);
        step();
        check("bp_hold1",   data_d,  8'h35);
        ready_d = 1'b1;
        #1;
        check("bp_rdy_hi",  ready_s, 4'b0001);
        step();
        set_src(0, 8'h98, 1'b1);
        #1;
        check("bp_ac",      data_d,  8'hAC);
        check("bp_ac_v",    valid_d, 1);
        step();
        valid_s = 4'b0000;
        #1;
        check("bp_98",      data_d,  8'h98);
        check("bp_98_last", last_d,  1);
        step();
        check("bp_drain",   valid_d, 0);

        // ---------------- async reset while locked on source 3 -------------
        rst     = 1'b1;
        valid_s = 4'b1000;
        set_src(3, 8'h3C, 1'b0);
        step();
        rst = 1'b0;
        step();
        check("ar_valid_pre", valid_d, 1);
        check("ar_src_pre",   src_d,   3);
        rst = 1'b1;
        #2;
        check("ar_valid_async", valid_d, 0);
        check("ar_src_async",   src_d,   0);
        valid_s = 4'b1010;
        set_src(1, 8'h55, 1'b1);
        step();
        rst = 1'b0;
        #1;
        check("ar_rdy_idle", ready_s, 4'b0010);
        step();
        check("ar_src1",  src_d,  1);
        check("ar_data1", data_d, 8'h55);

        // ---------------- N=3 pointer wrap, source 1 skipped ---------------
        rst     = 1'b1;
        valid_s = 4'b0000;
        v3      = 3'b010;
        step();
        rst = 1'b0;
        step();
        v3 = 3'b101;
        #1;
        check("n3_src_s1", sd3, 1);
        check("n3_rdy0",   r3,  3'b100);
        step();
        check("n3_src_a",  sd3, 2);
        check("n3_data_a", dd3, 8'h22);
        check("n3_rdy1",   r3,  3'b001);
        step();
        check("n3_src_b",  sd3, 0);
        check("n3_data_b", dd3, 8'h20);
        check("n3_rdy2",   r3,  3'b100);
        step();
        check("n3_src_c",  sd3, 2);
        step();
        check("n3_src_d",  sd3, 0);
        check("n3_valid",  vd3, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
